branch_predictor: RTL and testbench

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

---
 rtl/riscv_pkg.sv | 62 ++++++
 rtl/return_addr_stack.sv | 61 ++++++
 rtl/branch_predictor.sv | 115 +++++++++++
 tb/tb_branch_predictor.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end types: branch predictor table entries, update bundle and prediction.
// Sizing defaults live here so the predictor and the return-address stack agree.
package riscv_pkg;

    localparam int XLEN               = 32;
    localparam int BTB_SIZE           = 64;
    localparam int RAS_SIZE           = 8;
    localparam int BTB_INDEX_WIDTH    = $clog2(BTB_SIZE);
    localparam int BTB_TAG_WIDTH      = XLEN - BTB_INDEX_WIDTH - 2;
    localparam int PERF_COUNTER_WIDTH = 32;

    typedef enum logic [1:0] {
        STRONG_NOT_TAKEN = 2'd0,
        WEAK_NOT_TAKEN   = 2'd1,
        WEAK_TAKEN       = 2'd2,
        STRONG_TAKEN     = 2'd3
    } bp_state_e;

    typedef struct packed {
        logic            valid;
        logic            taken;
        logic [XLEN-1:0] target;
        bp_state_e       state;
    } branch_pred_t;

    typedef struct packed {
        logic                     valid;
        logic [BTB_TAG_WIDTH-1:0] tag;
        logic [XLEN-1:0]          target;
        bp_state_e                state;
        logic                     is_jump;
        logic                     is_ret;
    } btb_entry_t;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic            is_branch;
        logic            is_jump;
        logic            is_call;
        logic            is_return;
        logic            taken;
        logic [XLEN-1:0] target;
        logic            mispredict;
    } bp_update_t;

    localparam btb_entry_t BTB_ENTRY_RST = '{
        valid: 1'b0, tag: '0, target: '0, state: WEAK_NOT_TAKEN, is_jump: 1'b0, is_ret: 1'b0
    };

    function automatic bp_state_e bp_sat_step(bp_state_e s, logic taken);
        logic [1:0] v;
        v = s;
        if (taken && v != 2'd3) begin
            v = v + 2'd1;
        end else if (!taken && v != 2'd0) begin
            v = v - 2'd1;
        end
        return bp_state_e'(v);
    endfunction

endpackage

// File: rtl/return_addr_stack.sv
// Circular return-address stack; only compiled when BP_RAS_EN is defined.
// Full push overwrites the oldest slot; pop when empty is ignored; push+pop replaces top.
`ifdef BP_RAS_EN
module return_addr_stack
    import riscv_pkg::*;
#(
    parameter int DEPTH = RAS_SIZE
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            push,
    input  logic            pop,
    input  logic [XLEN-1:0] push_addr,
    output logic [XLEN-1:0] top,
    output logic            empty
);

    localparam int PW = $clog2(DEPTH);

    logic [XLEN-1:0] stack_q [DEPTH];
    logic [XLEN-1:0] stack_d [DEPTH];
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [PW:0]     cnt_q, cnt_d;
    logic [PW-1:0]   top_idx;

    assign top_idx = ptr_q - PW'(1);
    assign top     = stack_q[top_idx];
    assign empty   = (cnt_q == '0);

    always_comb begin
        stack_d = stack_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        if (push && pop && !empty) begin
            stack_d[top_idx] = push_addr;
        end else if (push) begin
            // ptr wraps, so a push into a full stack lands on the oldest slot
            stack_d[ptr_q] = push_addr;
            ptr_d          = ptr_q + PW'(1);
            if (cnt_q != (PW+1)'(DEPTH)) begin
                cnt_d = cnt_q + (PW+1)'(1);
            end
        end else if (pop && !empty) begin
            ptr_d = top_idx;
            cnt_d = cnt_q - (PW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q <= '0;
            cnt_q <= '0;
        end else begin
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            stack_q <= stack_d;
        end
    end

endmodule
`endif

// File: rtl/branch_predictor.sv
// BTB with 2-bit saturating counters, zero-latency lookup, optional RAS (BP_RAS_EN).
// Updates land the cycle after upd_valid; same-cycle lookups see pre-update contents.
module branch_predictor
    import riscv_pkg::*;
#(
    parameter int BTB_ENTRIES = BTB_SIZE,
    parameter int RAS_DEPTH   = RAS_SIZE
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [XLEN-1:0]               if_pc,
    output branch_pred_t                  pred,
    input  logic                          upd_valid,
    input  logic [XLEN-1:0]               upd_pc,
    input  logic                          upd_is_branch,
    input  logic                          upd_is_jump,
    input  logic                          upd_is_call,
    input  logic                          upd_is_return,
    input  logic                          upd_taken,
    input  logic [XLEN-1:0]               upd_target,
    input  logic                          upd_mispredict,
    output logic [PERF_COUNTER_WIDTH-1:0] perf_lookups,
    output logic [PERF_COUNTER_WIDTH-1:0] perf_mispredicts
);

    localparam int IDX_W = $clog2(BTB_ENTRIES);

    btb_entry_t                    btb_q [BTB_ENTRIES];
    btb_entry_t                    btb_d [BTB_ENTRIES];
    logic [PERF_COUNTER_WIDTH-1:0] lookups_q, lookups_d;
    logic [PERF_COUNTER_WIDTH-1:0] mispred_q, mispred_d;

    bp_update_t               upd;
    logic [IDX_W-1:0]         lk_idx, up_idx;
    logic [BTB_TAG_WIDTH-1:0] lk_tag, up_tag;
    btb_entry_t               lk_e, up_e;
    logic                     up_hit;
    logic [XLEN-1:0]          ras_top;
    logic                     ras_empty;

    assign upd = '{valid: upd_valid, pc: upd_pc, is_branch: upd_is_branch, is_jump: upd_is_jump,
                   is_call: upd_is_call, is_return: upd_is_return, taken: upd_taken,
                   target: upd_target, mispredict: upd_mispredict};

    assign lk_idx = if_pc[IDX_W+1:2];
    assign lk_tag = BTB_TAG_WIDTH'(if_pc >> (IDX_W + 2));
    assign up_idx = upd.pc[IDX_W+1:2];
    assign up_tag = BTB_TAG_WIDTH'(upd.pc >> (IDX_W + 2));
    assign lk_e   = btb_q[lk_idx];
    assign up_e   = btb_q[up_idx];
    assign up_hit = up_e.valid && (up_e.tag == up_tag);

`ifdef BP_RAS_EN
    return_addr_stack #(.DEPTH(RAS_DEPTH)) u_ras (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (upd.valid && upd.is_call),
        .pop       (upd.valid && upd.is_return),
        .push_addr (upd.pc + XLEN'(4)),
        .top       (ras_top),
        .empty     (ras_empty)
    );
`else
    logic unused_ras;
    assign ras_top    = '0;
    assign ras_empty  = 1'b1;
    assign unused_ras = upd.is_call ^ (RAS_DEPTH == 0);
`endif

    always_comb begin
        pred = '0;
        if (lk_e.valid && (lk_e.tag == lk_tag)) begin
            pred.valid  = 1'b1;
            pred.state  = lk_e.state;
            pred.taken  = lk_e.is_jump || (lk_e.state inside {WEAK_TAKEN, STRONG_TAKEN});
            pred.target = (lk_e.is_ret && !ras_empty) ? ras_top : lk_e.target;
        end
    end

    always_comb begin
        btb_d     = btb_q;
        lookups_d = lookups_q + PERF_COUNTER_WIDTH'(1);
        mispred_d = mispred_q + PERF_COUNTER_WIDTH'(upd.valid && upd.mispredict);
        if (upd.valid && (upd.is_branch || upd.is_jump)) begin
            if (up_hit) begin
                btb_d[up_idx].state = bp_sat_step(up_e.state, upd.taken);
                if (upd.taken) begin
                    btb_d[up_idx].target = upd.target;
                end
            end else if (upd.taken) begin
                btb_d[up_idx] = '{valid: 1'b1, tag: up_tag, target: upd.target,
                                  state: upd.is_jump ? STRONG_TAKEN : WEAK_TAKEN,
                                  is_jump: upd.is_jump, is_ret: upd.is_return};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                btb_q[i] <= BTB_ENTRY_RST;
            end
            lookups_q <= '0;
            mispred_q <= '0;
        end else begin
            btb_q     <= btb_d;
            lookups_q <= lookups_d;
            mispred_q <= mispred_d;
        end
    end

    assign perf_lookups     = lookups_q;
    assign perf_mispredicts = mispred_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: directed vector table, hand sequences, randomized traffic vs a table model.
// RAS sequences are included when BP_RAS_EN is defined.
module tb_branch_predictor;
    import riscv_pkg::*;

    logic            clk;
    logic            rst_n;
    logic [XLEN-1:0] if_pc;
    branch_pred_t    pred;
    logic            upd_valid, upd_is_branch, upd_is_jump, upd_is_call, upd_is_return;
    logic            upd_taken, upd_mispredict;
    logic [XLEN-1:0] upd_pc, upd_target;
    logic [31:0]     perf_lookups, perf_mispredicts;

    branch_predictor dut (
        .clk(clk), .rst_n(rst_n), .if_pc(if_pc), .pred(pred),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_is_branch(upd_is_branch),
        .upd_is_jump(upd_is_jump), .upd_is_call(upd_is_call), .upd_is_return(upd_is_return),
        .upd_taken(upd_taken), .upd_target(upd_target), .upd_mispredict(upd_mispredict),
        .perf_lookups(perf_lookups), .perf_mispredicts(perf_mispredicts)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: 64 entries indexed by pc word address, RAS as a bounded queue.
    bit          m_v   [64];
    logic [31:0] m_tag [64];
    logic [31:0] m_tgt [64];
    int          m_st  [64];
    bit          m_j   [64];
    bit          m_r   [64];
    logic [31:0] ras [$];
    logic [31:0] m_lookups, m_mispred;

    function automatic void model_reset();
        for (int i = 0; i < 64; i++) begin
            m_v[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_st[i] = 1; m_j[i] = 0; m_r[i] = 0;
        end
        ras.delete();
        m_lookups = 0;
        m_mispred = 0;
    endfunction

    function automatic void model_update();
        int i;
        if (!upd_valid) return;
        i = int'((upd_pc >> 2) % 64);
`ifdef BP_RAS_EN
        if (upd_is_call && upd_is_return) begin
            if (ras.size() > 0) ras[ras.size()-1] = upd_pc + 4;
            else ras.push_back(upd_pc + 4);
        end else if (upd_is_call) begin
            ras.push_back(upd_pc + 4);
            if (ras.size() > 8) void'(ras.pop_front());
        end else if (upd_is_return && ras.size() > 0) begin
            void'(ras.pop_back());
        end
`endif
        if (upd_is_branch || upd_is_jump) begin
            if (m_v[i] && m_tag[i] == (upd_pc >> 8)) begin
                if (upd_taken) begin
                    m_st[i]  = (m_st[i] == 3) ? 3 : m_st[i] + 1;
                    m_tgt[i] = upd_target;
                end else begin
                    m_st[i] = (m_st[i] == 0) ? 0 : m_st[i] - 1;
                end
            end else if (upd_taken) begin
                m_v[i] = 1; m_tag[i] = upd_pc >> 8; m_tgt[i] = upd_target;
                m_st[i] = upd_is_jump ? 3 : 2; m_j[i] = upd_is_jump; m_r[i] = upd_is_return;
            end
        end
    endfunction

    function automatic branch_pred_t model_pred(logic [31:0] pc);
        branch_pred_t p;
        int i;
        p = '0;
        i = int'((pc >> 2) % 64);
        if (m_v[i] && m_tag[i] == (pc >> 8)) begin
            p.valid  = 1'b1;
            p.state  = bp_state_e'(m_st[i]);
            p.taken  = m_j[i] || (m_st[i] >= 2);
            p.target = m_tgt[i];
`ifdef BP_RAS_EN
            if (m_r[i] && ras.size() > 0) p.target = ras[ras.size()-1];
`endif
        end
        return p;
    endfunction

    task automatic tick();
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            model_update();
            m_lookups = m_lookups + 1;
            if (upd_valid && upd_mispredict) m_mispred = m_mispred + 1;
        end
        @(negedge clk);
    endtask

    task automatic drive(input bit uv, input bit br, input bit jp, input bit cl, input bit rt,
                         input bit tk, input bit mp, input logic [31:0] upc, input logic [31:0] utg);
        upd_valid = uv; upd_is_branch = br; upd_is_jump = jp; upd_is_call = cl;
        upd_is_return = rt; upd_taken = tk; upd_mispredict = mp; upd_pc = upc; upd_target = utg;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    endtask

    task automatic check_pred(input string nm, input branch_pred_t exp);
        checks++;
        if (pred !== exp) begin
            errors++;
            $display("FAIL %s: got v=%0b t=%0b tgt=%h st=%0d, required v=%0b t=%0b tgt=%h st=%0d",
                     nm, pred.valid, pred.taken, pred.target, pred.state,
                     exp.valid, exp.taken, exp.target, exp.state);
        end
    endtask

    task automatic check_val(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", nm, got, exp);
        end
    endtask

    function automatic branch_pred_t mkp(bit v, bit t, logic [31:0] tgt, int st);
        branch_pred_t p;
        p.valid = v; p.taken = t; p.target = tgt; p.state = bp_state_e'(st);
        return p;
    endfunction

    typedef struct {
        logic [31:0]  ipc;
        bit           uv, br, jp, tk, mp;
        logic [31:0]  upc, utg;
        branch_pred_t exp;
    } vec_t;

    function automatic vec_t mk(logic [31:0] ipc, bit uv, bit br, bit jp, bit tk, bit mp,
                                logic [31:0] upc, logic [31:0] utg, branch_pred_t exp);
        vec_t v;
        v.ipc = ipc; v.uv = uv; v.br = br; v.jp = jp; v.tk = tk; v.mp = mp;
        v.upc = upc; v.utg = utg; v.exp = exp;
        return v;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    vec_t tbl [16];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0]  = mk(32'h100, 1, 1, 0, 1, 0, 32'h100, 32'h200, mkp(0, 0, 0, 0));
        tbl[1]  = mk(32'h100, 0, 0, 0, 0, 0, 32'h0,   32'h0,   mkp(1, 1, 32'h200, 2));
        tbl[2]  = mk(32'h100, 1, 1, 0, 0, 0, 32'h100, 32'h0,   mkp(1, 1, 32'h200, 2));
        tbl[3]  = mk(32'h100, 1, 1, 0, 0, 0, 32'h100, 32'h0,   mkp(1, 0, 32'h200, 1));
        tbl[4]  = mk(32'h100, 1, 1, 0, 1, 0, 32'h100, 32'h300, mkp(1, 0, 32'h200, 0));
        tbl[5]  = mk(32'h200, 0, 0, 0, 0, 0, 32'h0,   32'h0,   mkp(0, 0, 0, 0));
        tbl[6]  = mk(32'h100, 1, 1, 0, 1, 0, 32'h100, 32'h300, mkp(1, 0, 32'h300, 1));
        tbl[7]  = mk(32'h100, 1, 1, 0, 1, 0, 32'h100, 32'h300, mkp(1, 1, 32'h300, 2));
        tbl[8]  = mk(32'h100, 1, 1, 0, 1, 0, 32'h100, 32'h300, mkp(1, 1, 32'h300, 3));
        tbl[9]  = mk(32'h100, 0, 0, 0, 0, 0, 32'h0,   32'h0,   mkp(1, 1, 32'h300, 3));
        tbl[10] = mk(32'h180, 1, 0, 0, 1, 0, 32'h180, 32'h500, mkp(0, 0, 0, 0));
        tbl[11] = mk(32'h180, 0, 0, 0, 0, 0, 32'h0,   32'h0,   mkp(0, 0, 0, 0));
        tbl[12] = mk(32'h180, 1, 0, 1, 1, 1, 32'h180, 32'h600, mkp(0, 0, 0, 0));
        tbl[13] = mk(32'h180, 0, 0, 0, 0, 0, 32'h0,   32'h0,   mkp(1, 1, 32'h600, 3));
        tbl[14] = mk(32'h1c0, 1, 1, 0, 0, 0, 32'h1c0, 32'h700, mkp(0, 0, 0, 0));
        tbl[15] = mk(32'h1c0, 0, 0, 0, 0, 0, 32'h0,   32'h0,   mkp(0, 0, 0, 0));

        idle();
        if_pc = 32'h100;
        rst_n = 1'b0;
        @(negedge clk);
        tick();
        #1;
        check_pred("reset_pred", mkp(0, 0, 0, 0));
        check_val("reset_lookups", perf_lookups, 32'd0);
        check_val("reset_mispred", perf_mispredicts, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            if_pc = tbl[i].ipc;
            drive(tbl[i].uv, tbl[i].br, tbl[i].jp, 0, 0, tbl[i].tk, tbl[i].mp, tbl[i].upc, tbl[i].utg);
            #1;
            check_pred($sformatf("vec%0d", i), tbl[i].exp);
            tick();
        end
        idle();
        #1;
        check_val("tbl_lookups", perf_lookups, 32'd16);
        check_val("tbl_mispred", perf_mispredicts, 32'd1);

        // Three mispredict pulses from a clean reset
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 0, 0, 0, 0, 1, 32'h0, 32'h0);
            tick();
        end
        idle();
        tick();
        #1;
        check_val("mispred_x3", perf_mispredicts, 32'd3);
        check_val("lookups_4", perf_lookups, 32'd4);

        // Reset asserted during an allocating update discards it
        rst_n = 1'b0;
        drive(1, 1, 0, 0, 0, 1, 0, 32'h100, 32'h200);
        tick();
        rst_n = 1'b1;
        idle();
        if_pc = 32'h100;
        #1;
        check_pred("reset_discards_upd", mkp(0, 0, 0, 0));

`ifdef BP_RAS_EN
        do_reset();
        drive(1, 0, 1, 0, 1, 1, 0, 32'h80, 32'h999);
        tick();
        idle();
        if_pc = 32'h80;
        #1;
        check_pred("ret_empty_ras", mkp(1, 1, 32'h999, 3));
        drive(1, 0, 0, 1, 0, 0, 0, 32'h40, 32'h0);
        tick();
        idle();
        #1;
        check_pred("ret_uses_ras", mkp(1, 1, 32'h44, 3));
        for (int k = 0; k < 9; k++) begin
            drive(1, 0, 0, 1, 0, 0, 0, 32'h400 + 32'(16 * k), 32'h0);
            tick();
        end
        idle();
        #1;
        check_pred("ras_after_9_calls", mkp(1, 1, 32'h484, 3));
        for (int k = 0; k < 9; k++) begin
            drive(1, 0, 0, 0, 1, 0, 0, 32'h0, 32'h0);
            tick();
            idle();
            #1;
            check_pred($sformatf("ras_pop%0d", k), model_pred(32'h80));
        end
        check_pred("ras_drained", mkp(1, 1, 32'h999, 3));
        drive(1, 0, 0, 1, 1, 0, 0, 32'h60, 32'h0);
        tick();
        idle();
        #1;
        check_pred("ras_callret_empty", mkp(1, 1, 32'h64, 3));
`endif

        // Randomized traffic over a small pc pool so hits, aliases and saturation all occur
        do_reset();
        for (int n = 0; n < 400; n++) begin
            int r;
            logic [31:0] upc;
            if_pc = (32'($urandom_range(0, 2)) << 8) | (32'($urandom_range(0, 3)) << 2);
            upc   = (32'($urandom_range(0, 2)) << 8) | (32'($urandom_range(0, 3)) << 2);
            r = $urandom_range(0, 5);
            case (r)
                0:       idle();
                3:       drive(1, 0, 1, $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0, 1,
                               1'($urandom), upc, $urandom & 32'hfffc);
                4:       drive(1, 0, 0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                               upc, $urandom & 32'hfffc);
                default: drive(1, 1, 0, 0, 0, 1'($urandom), 1'($urandom), upc, $urandom & 32'hfffc);
            endcase
            #1;
            check_pred($sformatf("rand%0d", n), model_pred(if_pc));
            if (n % 50 == 49) begin
                check_val("rand_lookups", perf_lookups, m_lookups);
                check_val("rand_mispred", perf_mispredicts, m_mispred);
            end
            tick();
        end
        idle();
        #1;
        check_val("final_lookups", perf_lookups, m_lookups);
        check_val("final_mispred", perf_mispredicts, m_mispred);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
